alu_arbiter_16: RTL and testbench



---
 rtl/alu_arbiter_16_if.sv | 53 +++++
 rtl/alu_arbiter_16.sv | 112 +++++++++++
 tb/tb_alu_arbiter_16.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_16_if.sv
// Bundle of the two requester ports, the shared response port, the ALU hookup and status.
// The DUT takes the slave modport; the environment that drives requests and models the ALU takes master.
interface alu_arbiter_16_if #(
    parameter int unsigned WIDTH = 16
);
    localparam int unsigned FN_W   = 6;
    localparam int unsigned FLAG_W = 3;
    localparam int unsigned CNT_W  = 16;

    logic              req0_valid;
    logic              req0_ready;
    logic [WIDTH-1:0]  req0_a;
    logic [WIDTH-1:0]  req0_b;
    logic [FN_W-1:0]   req0_alufn;
    logic              req1_valid;
    logic              req1_ready;
    logic [WIDTH-1:0]  req1_a;
    logic [WIDTH-1:0]  req1_b;
    logic [FN_W-1:0]   req1_alufn;
    logic              rsp0_valid;
    logic              rsp0_ready;
    logic              rsp1_valid;
    logic              rsp1_ready;
    logic [WIDTH-1:0]  rsp_out;
    logic [FLAG_W-1:0] rsp_flags;
    logic [WIDTH-1:0]  alu_a;
    logic [WIDTH-1:0]  alu_b;
    logic [FN_W-1:0]   alu_alufn;
    logic [WIDTH-1:0]  alu_out;
    logic              alu_z;
    logic              alu_n;
    logic              alu_v;
    logic              busy;
    logic [CNT_W-1:0]  op_count;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_alufn,
        input  req1_valid, req1_a, req1_b, req1_alufn,
        input  rsp0_ready, rsp1_ready,
        input  alu_out, alu_z, alu_n, alu_v,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        output rsp_out, rsp_flags, alu_a, alu_b, alu_alufn, busy, op_count
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_alufn,
        output req1_valid, req1_a, req1_b, req1_alufn,
        output rsp0_ready, rsp1_ready,
        output alu_out, alu_z, alu_n, alu_v,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        input  rsp_out, rsp_flags, alu_a, alu_b, alu_alufn, busy, op_count
    );
endinterface

// File: rtl/alu_arbiter_16.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Each operation runs IDLE (accept) -> EXEC (capture result) -> RESP (hold until consumed).
module alu_arbiter_16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    alu_arbiter_16_if.slave bus
);
    localparam int unsigned FN_W   = 6;
    localparam int unsigned FLAG_W = 3;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              gnt_q, gnt_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [FN_W-1:0]   fn_q, fn_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req0_ready_c, req1_ready_c;
    logic              sel_c, any_c, rsp_hs_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            gnt_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            fn_q    <= '0;
            out_q   <= '0;
            flags_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fn_q    <= fn_d;
            out_q   <= out_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        a_d          = a_q;
        b_d          = b_q;
        fn_d         = fn_q;
        out_d        = out_q;
        flags_d      = flags_q;
        cnt_d        = cnt_q;
        req0_ready_c = 1'b0;
        req1_ready_c = 1'b0;
        // Pointer requester first, otherwise whichever one is valid.
        sel_c        = (ptr_q ? bus.req1_valid : bus.req0_valid) ? ptr_q : ~ptr_q;
        any_c        = bus.req0_valid | bus.req1_valid;
        rsp_hs_c     = gnt_q ? bus.rsp1_ready : bus.rsp0_ready;

        unique case (state_q)
            IDLE: begin
                if (any_c && !rst) begin
                    req0_ready_c = ~sel_c;
                    req1_ready_c = sel_c;
                    gnt_d        = sel_c;
                    a_d          = sel_c ? bus.req1_a     : bus.req0_a;
                    b_d          = sel_c ? bus.req1_b     : bus.req0_b;
                    fn_d         = sel_c ? bus.req1_alufn : bus.req0_alufn;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                out_d   = bus.alu_out;
                flags_d = {bus.alu_z, bus.alu_n, bus.alu_v};
                state_d = RESP;
            end
            RESP: begin
                if (rsp_hs_c) begin
                    ptr_d   = ~gnt_q;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req0_ready = req0_ready_c;
    assign bus.req1_ready = req1_ready_c;
    assign bus.rsp0_valid = (state_q == RESP) && !gnt_q;
    assign bus.rsp1_valid = (state_q == RESP) &&  gnt_q;
    assign bus.rsp_out    = out_q;
    assign bus.rsp_flags  = flags_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_alufn  = fn_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.op_count   = cnt_q;
endmodule

// File: tb/tb_alu_arbiter_16.sv
// Directed bench for alu_arbiter_16 with a small ADD/SUB ALU hung on the shared ALU port.
module tb_alu_arbiter_16;
    localparam int unsigned WIDTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    alu_arbiter_16_if #(.WIDTH(WIDTH)) bus ();

    alu_arbiter_16 #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Environment ALU: 0 = ADD, 1 = SUB, anything else passes a through.
    always_comb begin
        logic [WIDTH-1:0] r;
        logic             v;
        v = 1'b0;
        case (bus.alu_alufn)
            6'd0: begin
                r = bus.alu_a + bus.alu_b;
                v = (bus.alu_a[WIDTH-1] == bus.alu_b[WIDTH-1]) && (r[WIDTH-1] != bus.alu_a[WIDTH-1]);
            end
            6'd1: begin
                r = bus.alu_a - bus.alu_b;
                v = (bus.alu_a[WIDTH-1] != bus.alu_b[WIDTH-1]) && (r[WIDTH-1] != bus.alu_a[WIDTH-1]);
            end
            default: r = bus.alu_a;
        endcase
        bus.alu_out = r;
        bus.alu_z   = (r == '0);
        bus.alu_n   = r[WIDTH-1];
        bus.alu_v   = v;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit id, input bit vld, input logic [15:0] a,
                           input logic [15:0] b, input logic [5:0] fn);
        if (id) begin
            bus.req1_valid = vld; bus.req1_a = a; bus.req1_b = b; bus.req1_alufn = fn;
        end else begin
            bus.req0_valid = vld; bus.req0_a = a; bus.req0_b = b; bus.req0_alufn = fn;
        end
    endtask

    // One lone-requester transaction, started in an IDLE cycle.
    task automatic do_op(input string tag, input bit id, input logic [15:0] a, input logic [15:0] b,
                         input logic [5:0] fn, input logic [15:0] exp_out, input logic [2:0] exp_flags,
                         input logic [15:0] exp_cnt);
        set_req(id, 1'b1, a, b, fn);
        #1;
        check({tag, "_ready"}, {30'd0, bus.req1_ready, bus.req0_ready}, id ? 32'd2 : 32'd1);
        tick();
        set_req(id, 1'b0, 16'h0, 16'h0, 6'h0);
        #1;
        check({tag, "_exec_busy"}, {31'd0, bus.busy}, 32'd1);
        check({tag, "_exec_rdy"}, {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
        check({tag, "_exec_vld"}, {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
        check({tag, "_alu_ops"}, {bus.alu_a, bus.alu_b}, {a, b});
        check({tag, "_alu_fn"}, {26'd0, bus.alu_alufn}, {26'd0, fn});
        tick();
        check({tag, "_rsp_vld"}, {30'd0, bus.rsp1_valid, bus.rsp0_valid}, id ? 32'd2 : 32'd1);
        check({tag, "_rsp_out"}, {16'd0, bus.rsp_out}, {16'd0, exp_out});
        check({tag, "_rsp_flags"}, {29'd0, bus.rsp_flags}, {29'd0, exp_flags});
        if (id) bus.rsp1_ready = 1'b1; else bus.rsp0_ready = 1'b1;
        tick();
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        #1;
        check({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_cnt"}, {16'd0, bus.op_count}, {16'd0, exp_cnt});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_req(1'b0, 1'b0, 16'h0, 16'h0, 6'h0);
        set_req(1'b1, 1'b0, 16'h0, 16'h0, 6'h0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_cnt", {16'd0, bus.op_count}, 32'd0);
        check("rst_out", {13'd0, bus.rsp_flags, bus.rsp_out}, 32'd0);
        check("rst_vld_rdy", {28'd0, bus.rsp1_valid, bus.rsp0_valid, bus.req1_ready, bus.req0_ready}, 32'd0);
        check("rst_alu", {bus.alu_a, bus.alu_b}, 32'd0);

        // Basic ops: ADD, SUB to zero, signed overflow
        do_op("add", 1'b0, 16'h0003, 16'h0004, 6'd0, 16'h0007, 3'b000, 16'd1);
        do_op("sub", 1'b1, 16'h0005, 16'h0005, 6'd1, 16'h0000, 3'b100, 16'd2);
        do_op("ovf", 1'b0, 16'h7FFF, 16'h0001, 6'd0, 16'h8000, 3'b011, 16'd3);

        // Continuous contention from reset, response readys tied high
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(1'b0, 1'b1, 16'h0001, 16'h0001, 6'd0);
        set_req(1'b1, 1'b1, 16'h000A, 16'h0014, 6'd0);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("rr_grant", {30'd0, bus.req1_ready, bus.req0_ready}, (i % 2 == 1) ? 32'd2 : 32'd1);
            tick();
            check("rr_exec_rdy", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
            tick();
            check("rr_rsp_vld", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, (i % 2 == 1) ? 32'd2 : 32'd1);
            check("rr_rsp_out", {16'd0, bus.rsp_out}, (i % 2 == 1) ? 32'h1E : 32'h2);
            tick();
        end
        check("rr_cnt", {16'd0, bus.op_count}, 32'd4);

        // Backpressure on rsp0 while req1 waits; stray rsp1_ready must be ignored
        bus.rsp0_ready = 1'b0;
        set_req(1'b0, 1'b1, 16'h0100, 16'h0023, 6'd0);
        set_req(1'b1, 1'b1, 16'h0002, 16'h0003, 6'd1);
        #1;
        check("bp_grant", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd1);
        tick();
        set_req(1'b0, 1'b0, 16'h0, 16'h0, 6'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_vld", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd1);
            check("bp_hold_out", {16'd0, bus.rsp_out}, 32'h0123);
            check("bp_req1_wait", {31'd0, bus.req1_ready}, 32'd0);
            tick();
        end
        bus.rsp0_ready = 1'b1;
        #1;
        check("bp_req1_hs", {31'd0, bus.req1_ready}, 32'd0);
        tick();
        bus.rsp0_ready = 1'b0;
        #1;
        check("bp_req1_acc", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd2);
        check("bp_cnt5", {16'd0, bus.op_count}, 32'd5);
        tick();
        set_req(1'b1, 1'b0, 16'h0, 16'h0, 6'h0);
        tick();
        check("bp_rsp1_vld", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd2);
        check("bp_rsp1_out", {13'd0, bus.rsp_flags, bus.rsp_out}, {13'd0, 3'b010, 16'hFFFF});
        tick();
        bus.rsp1_ready = 1'b0;
        #1;
        check("bp_cnt6", {16'd0, bus.op_count}, 32'd6);

        // Move pointer to 1, then reset mid-EXEC of a req1 operation
        do_op("pre", 1'b0, 16'h0010, 16'h0001, 6'd1, 16'h000F, 3'b000, 16'd7);
        set_req(1'b0, 1'b1, 16'h0004, 16'h0004, 6'd0);
        set_req(1'b1, 1'b1, 16'h0009, 16'h0001, 6'd0);
        #1;
        check("rx_grant1", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd2);
        tick();
        set_req(1'b0, 1'b0, 16'h0, 16'h0, 6'h0);
        set_req(1'b1, 1'b0, 16'h0, 16'h0, 6'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rx_busy", {31'd0, bus.busy}, 32'd0);
        check("rx_cnt", {16'd0, bus.op_count}, 32'd0);
        check("rx_out", {13'd0, bus.rsp_flags, bus.rsp_out}, 32'd0);
        tick();
        check("rx_no_rsp", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
        set_req(1'b0, 1'b1, 16'h0004, 16'h0004, 6'd0);
        set_req(1'b1, 1'b1, 16'h0009, 16'h0001, 6'd0);
        #1;
        check("rx_prio0", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd1);
        set_req(1'b1, 1'b0, 16'h0, 16'h0, 6'h0);
        #1;
        do_op("rx_op", 1'b0, 16'h0004, 16'h0004, 6'd0, 16'h0008, 3'b000, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
